// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR job scheduler
//
// Purpose: default datapath widths, packet size limit, scheduler FSM state
// type and the saturating event-counter helper.
package fir_pkg;

  localparam int FIR_IN_W        = 16;  // input sample width
  localparam int FIR_OUT_W       = 32;  // filtered sample width
  localparam int FIR_SAMPLES_MAX = 8;   // largest packet the SPI side can carry
  localparam int FIR_CNT_W       = 8;   // overrun / timeout counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } fir_state_t;

  // Event counters stick at all-ones rather than wrapping.
  function automatic logic [FIR_CNT_W-1:0] sat_inc(input logic [FIR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fir_job_fifo.sv
// rtl/fir_job_fifo.sv - two-entry packet FIFO with simultaneous push/pop
//
// Purpose: holds received packets waiting for the filter.
// Ports:
//   clk, nResetIn  clock, asynchronous active-low reset
//   push, pop      write / remove head (both allowed in one cycle)
//   wdata          entry written on push
//   head           oldest entry (registered)
//   level          occupancy 0..2
module fir_job_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nResetIn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   level
);

  logic [W-1:0] tail;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop && (level != 2'd0);
  assign push_ok = push && ((level != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      head  <= '0;
      tail  <= '0;
      level <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (level == 2'd0) head <= wdata;
          else               tail <= wdata;
          level <= level + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          level <= level - 2'd1;
        end
        2'b11: begin
          // Level unchanged: the new entry lands behind whatever remains.
          if (level == 2'd2) begin
            head <= tail;
            tail <= wdata;
          end else begin
            head <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_job_scheduler.sv
// rtl/fir_job_scheduler.sv - queues SPI packets and sequences FIR filter jobs
//
// Purpose: buffers received packets, runs one filter job at a time over the
// start/done handshake with a watchdog, and holds the last result for the
// SPI transmit side.
// Ports:
//   clk, nResetIn                   clock, asynchronous active-low reset
//   rxValidIn, rxDataIn             received packet pulse and samples
//   txDataOut                       result shifted out on the next packet
//   firStartOut, firDataOut         job start pulse and job samples (FIFO head)
//   firBusyIn, firDoneIn, firResultIn  filter status, completion and result
//   overrunOut, overrunCntOut       dropped-packet pulse and saturating count
//   timeoutOut, timeoutCntOut       aborted-job pulse and saturating count
//   levelOut                        FIFO occupancy
//   busyOut                         FSM not idle
module fir_job_scheduler
  import fir_pkg::*;
#(
  parameter int SAMPLES_NUM    = FIR_SAMPLES_MAX,
  parameter int IN_W           = FIR_IN_W,
  parameter int OUT_W          = FIR_OUT_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         nResetIn,
  input  logic                         rxValidIn,
  input  logic [IN_W*SAMPLES_NUM-1:0]  rxDataIn,
  output logic [OUT_W*SAMPLES_NUM-1:0] txDataOut,
  output logic                         firStartOut,
  output logic [IN_W*SAMPLES_NUM-1:0]  firDataOut,
  input  logic                         firBusyIn,
  input  logic                         firDoneIn,
  input  logic [OUT_W*SAMPLES_NUM-1:0] firResultIn,
  output logic                         overrunOut,
  output logic                         timeoutOut,
  output logic [FIR_CNT_W-1:0]         overrunCntOut,
  output logic [FIR_CNT_W-1:0]         timeoutCntOut,
  output logic [1:0]                   levelOut,
  output logic                         busyOut
);

  localparam int RW   = OUT_W * SAMPLES_NUM;
  localparam int DW   = IN_W * SAMPLES_NUM;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  fir_state_t      state, state_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic [RW-1:0]   hold;
  logic            done_hit;
  logic            timeout_hit;
  logic            pop;
  logic            push_ok;

  // Done wins over the watchdog when both land on the last WAIT cycle.
  assign done_hit    = (state == ST_WAIT) && firDoneIn;
  assign timeout_hit = (state == ST_WAIT) && !firDoneIn && (wd_cnt == WD_LAST);
  assign pop         = done_hit || timeout_hit;
  assign push_ok     = rxValidIn && ((levelOut != 2'd2) || pop);

  fir_job_fifo #(.W(DW)) u_fifo (
    .clk      (clk),
    .nResetIn (nResetIn),
    .push     (rxValidIn),
    .pop      (pop),
    .wdata    (rxDataIn),
    .head     (firDataOut),
    .level    (levelOut)
  );

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd_cnt;
    case (state)
      ST_IDLE: begin
        if ((levelOut != 2'd0) && !firBusyIn) state_nxt = ST_START;
      end
      ST_START: begin
        state_nxt = ST_WAIT;
        wd_nxt    = '0;
      end
      ST_WAIT: begin
        if (pop) state_nxt = ST_IDLE;
        else     wd_nxt    = wd_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state         <= ST_IDLE;
      wd_cnt        <= '0;
      hold          <= '0;
      txDataOut     <= '0;
      firStartOut   <= 1'b0;
      busyOut       <= 1'b0;
      overrunOut    <= 1'b0;
      timeoutOut    <= 1'b0;
      overrunCntOut <= '0;
      timeoutCntOut <= '0;
    end else begin
      state       <= state_nxt;
      wd_cnt      <= wd_nxt;
      // Flags follow the next state so they line up with the state register.
      firStartOut <= (state_nxt == ST_START);
      busyOut     <= (state_nxt != ST_IDLE);
      overrunOut  <= rxValidIn && !push_ok;
      timeoutOut  <= timeout_hit;

      if (rxValidIn && !push_ok) overrunCntOut <= sat_inc(overrunCntOut);
      if (timeout_hit)           timeoutCntOut <= sat_inc(timeoutCntOut);

      if (done_hit)         hold <= firResultIn;
      else if (timeout_hit) hold <= '0;

      // Reads the pre-update holding value, so a same-cycle done shows up
      // only on the following packet.
      if (rxValidIn) txDataOut <= hold;
    end
  end

endmodule

// File: doc/fir_job_scheduler.md
# fir_job_scheduler

Sequencing controller between the SPI packet receiver and the FIR filter datapath. It queues received sample packets in a 2-entry FIFO and issues one filter job at a time over the start/done handshake. Completed results go through a one-slot holding register that the SPI transmit side reads, which keeps the two-packet result latency. It also detects FIFO overrun and filter timeouts and counts both.

## Interface
Parameters:
- SAMPLES_NUM, 8, samples per packet (1..8)
- IN_W, 16, input sample width
- OUT_W, 32, output sample width
- TIMEOUT_CYCLES, 4096, maximum clk cycles spent in WAIT before a job is aborted (>= 2)

Ports:
- clk  in  1  system clock (100 MHz domain)
- nResetIn  in  1  asynchronous, active-low reset
- rxValidIn  in  1  one-cycle pulse: a packet has been received
- rxDataIn  in  IN_W*SAMPLES_NUM  received samples; valid while rxValidIn=1
- txDataOut  out  OUT_W*SAMPLES_NUM  data the SPI slave shifts out on the next packet
- firStartOut  out  1  one-cycle job start pulse to the filter
- firDataOut  out  IN_W*SAMPLES_NUM  job samples; stable from START through WAIT
- firBusyIn  in  1  filter busy
- firDoneIn  in  1  one-cycle job-complete pulse
- firResultIn  in  OUT_W*SAMPLES_NUM  filter result; valid while firDoneIn=1
- overrunOut  out  1  one-cycle pulse: packet dropped
- timeoutOut  out  1  one-cycle pulse: job aborted
- overrunCntOut  out  8  saturating count of dropped packets
- timeoutCntOut  out  8  saturating count of aborted jobs
- levelOut  out  2  FIFO occupancy (0..2)
- busyOut  out  1  FSM not in IDLE

## Operation
- Reset value of every output is 0. The FIFO, holding register, counters and FSM state are all cleared.
- FIFO push:
  - Triggered by rxValidIn.
  - Accepted when level < 2, or when a pop occurs in the same cycle.
  - Otherwise the packet is dropped, overrunOut pulses and overrunCntOut increments, saturating at 255.
- FIFO pop:
  - On the WAIT exit, whether by done or by timeout.
  - Order is strictly FIFO.
- FSM states IDLE, START, WAIT:
  - IDLE→START when level > 0 and firBusyIn = 0.
  - START asserts firStartOut for exactly one cycle, then moves to WAIT and clears the watchdog.
  - WAIT→IDLE on firDoneIn. The holding register loads firResultIn and the FIFO pops.
  - WAIT→IDLE when the watchdog reaches TIMEOUT_CYCLES with no done:
    - the holding register loads 0;
    - the FIFO pops;
    - timeoutOut pulses;
    - timeoutCntOut increments, saturating.
  - firDoneIn outside WAIT is ignored.
- firDataOut always presents the FIFO head entry.
- On every rxValidIn (push accepted or not), txDataOut loads the holding register.
  - If a done and an rxValidIn occur in the same cycle, txDataOut takes the old holding value. The new result appears on the following packet.
- A reset in the middle of a job returns the FSM to IDLE immediately. The filter's own state is not the concern of this block.

## Timing
- rxValidIn at cycle N with empty FIFO, IDLE and firBusyIn=0:
  - levelOut=1 at N+1;
  - state=START at N+2, with firStartOut=1 during N+2;
  - WAIT from N+3.
- firDoneIn at cycle M: holding register updated, levelOut decremented and busyOut=0 at M+1. The next START can occur no earlier than M+2.
- Watchdog counts clk cycles in WAIT. Abort happens on the TIMEOUT_CYCLES-th cycle in WAIT.
- All outputs are registered. No combinational path from input to output except none.
- A result reaches txDataOut on the first rxValidIn after its done. It is shifted out during the following SPI packet, i.e. two packets after its input.

## Structure
- Shared package fir_pkg holds:
  - IN_W, OUT_W and the maximum SAMPLES_NUM;
  - the FSM enum type (IDLE, START, WAIT);
  - the saturating counter width (8).
- One natural sub-module: fir_job_fifo, a 2-deep FIFO with a parameterised width. It provides simultaneous push/pop, a level output and a head output.

## Test plan
All scenarios use SAMPLES_NUM=2 and a behavioural filter that returns sample×2 with a done delay of 20 cycles.
- Reset held low with rxValidIn toggling → every output 0, levelOut=0, no firStartOut.
- Single packet {0x0001,0x0002} → firStartOut exactly 2 cycles after rxValidIn with firDataOut={0x0001,0x0002}. The holding register is {2,4} after done. txDataOut={2,4} on the next rxValidIn.
- Three back-to-back packets 1 cycle apart with the filter busy → levelOut reaches 2, the third packet is dropped, overrunOut pulses once and overrunCntOut=1. The first two jobs complete in order.
- Filter that never asserts done, TIMEOUT_CYCLES=16 → timeoutOut pulses 16 cycles into WAIT, timeoutCntOut=1, the entry is popped and the holding register is 0.
- firDoneIn coincident with rxValidIn → txDataOut gets the previous result. The new result appears on the next rxValidIn.
- Reset asserted during WAIT, then released → FSM IDLE, levelOut=0. A new packet starts cleanly with the start pulse 2 cycles after rxValidIn.
